header_snapshot_ram: RTL and testbench

Parametrised header memory that builds the per-frame header placed in front of each data block sent over the host FIFO. It captures `frame_count` and `pps_count` atomically on a snapshot strobe and adds a magic word, a snapshot sequence number and user-writable words. The header can be read by random access, or streamed out as an `HDR_LEN`-word burst with a valid/ready handshake and a trailing XOR checksum. It sits between the frame/PPS counters and the FIFO write mux.

---
 rtl/header_snapshot_ram_if.sv | 38 +++
 rtl/header_snapshot_ram.sv | 150 +++++++++++++++
 tb/tb_header_snapshot_ram.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/header_snapshot_ram_if.sv
// Handshake and bus bundle for header_snapshot_ram: snapshot inputs, user writes,
// random reads and the streamed header burst.
interface header_snapshot_ram_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              snap;
  logic [DATA_W-1:0] frame_count;
  logic [DATA_W-1:0] pps_count;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              stream_start;
  logic [DATA_W-1:0] stream_data;
  logic              stream_valid;
  logic              stream_ready;
  logic              stream_last;
  logic              busy;
  logic              snap_dropped;

  modport master (
    output snap, frame_count, pps_count, wr_en, wr_addr, wr_data,
           rd_en, Address, stream_start, stream_ready,
    input  data_out, data_valid, stream_data, stream_valid,
           stream_last, busy, snap_dropped
  );

  modport slave (
    input  snap, frame_count, pps_count, wr_en, wr_addr, wr_data,
           rd_en, Address, stream_start, stream_ready,
    output data_out, data_valid, stream_data, stream_valid,
           stream_last, busy, snap_dropped
  );
endinterface

// File: rtl/header_snapshot_ram.sv
// Per-frame header memory: atomic frame/PPS snapshot, user words, random read port
// and a valid/ready header burst terminated by an XOR checksum word.
module header_snapshot_ram #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned HDR_LEN = 8,
  parameter logic [31:0] MAGIC   = 32'hA5A5_5A5A
) (
  input logic                 rd_clk,
  input logic                 rst,
  header_snapshot_ram_if.slave bus
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam int unsigned       USER_BASE = 4;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(HDR_LEN - 1);
  localparam logic [DATA_W-1:0] MAGIC_W   = DATA_W'(MAGIC);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] chk_q, chk_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              snap_dropped_q, snap_dropped_d;

  logic              stream_valid_c;
  logic              stream_last_c;
  logic              busy_c;
  logic [DATA_W-1:0] stream_data_c;
  logic              xfer_c;
  logic              snap_ok_c;
  logic              wr_ok_c;

  // Stream FSM state register
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
    end
  end

  // Stream FSM next state: walk the header, folding each accepted word into chk
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    case (state_q)
      S_IDLE: begin
        if (bus.stream_start) begin
          state_d = S_STREAM;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      S_STREAM: begin
        if (xfer_c) begin
          chk_d = chk_q ^ stream_data_c;
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream FSM outputs, decoded from the state flops
  always_comb begin
    stream_valid_c = 1'b0;
    stream_last_c  = 1'b0;
    busy_c         = 1'b0;
    stream_data_c  = mem_q[idx_q];
    if (idx_q == LAST_IDX) begin
      stream_data_c = chk_q;
    end
    if (state_q == S_STREAM) begin
      stream_valid_c = 1'b1;
      busy_c         = 1'b1;
      stream_last_c  = (idx_q == LAST_IDX);
    end
  end

  assign xfer_c    = stream_valid_c & bus.stream_ready;
  assign snap_ok_c = bus.snap & ~busy_c;
  assign wr_ok_c   = bus.wr_en & ~busy_c & (32'(bus.wr_addr) >= USER_BASE);

  // Header contents are frozen while a burst is in flight
  always_comb begin
    mem_d    = mem_q;
    mem_d[0] = MAGIC_W;
    if (snap_ok_c) begin
      mem_d[1] = bus.frame_count;
      mem_d[2] = bus.pps_count;
      mem_d[3] = mem_q[3] + DATA_W'(1);
    end
    if (wr_ok_c) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Random read port and drop indicator; reads see the pre-edge memory
  always_comb begin
    snap_dropped_d = bus.snap & busy_c;
    data_valid_d   = bus.rd_en;
    data_out_d     = data_out_q;
    if (bus.rd_en) begin
      data_out_d = mem_q[bus.Address];
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= (i == 0) ? MAGIC_W : '0;
      end
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      snap_dropped_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      snap_dropped_q <= snap_dropped_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.snap_dropped = snap_dropped_q;
  assign bus.stream_data  = stream_data_c;
  assign bus.stream_valid = stream_valid_c;
  assign bus.stream_last  = stream_last_c;
  assign bus.busy         = busy_c;

endmodule

// File: tb/tb_header_snapshot_ram.sv
// Directed bench for header_snapshot_ram: table of read/write/snap vectors plus
// hand-written burst sequences (back-pressure, mid-burst snap, reset, snap+start).
module tb_header_snapshot_ram;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned HDR_LEN = 8;
  localparam logic [31:0] MAGIC   = 32'hA5A5_5A5A;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  header_snapshot_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  header_snapshot_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .HDR_LEN(HDR_LEN),
    .MAGIC  (MAGIC)
  ) dut (
    .rd_clk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_SNAP} op_e;

  typedef struct {
    op_e         op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] pps;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_e op, input logic [3:0] addr, input logic [31:0] data,
                              input logic [31:0] pps, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.pps = pps; v.exp = exp;
    return v;
  endfunction

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    bus.rd_en   = 1'b1;
    bus.Address = addr;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check({name, "_valid"}, 32'(bus.data_valid), 32'd1);
    check(name, bus.data_out, exp);
  endtask

  // Drives a burst from the current negedge and checks every word as it is presented.
  // mode 0: ready held high; mode 1: ready toggles 1,0,1,0...
  task automatic do_burst(input string name, input int mode, input int snap_at,
                          input logic [31:0] e [8]);
    int cnt;
    int cyc;
    bit snapped;
    cnt = 0;
    cyc = 0;
    bus.stream_start = 1'b1;
    @(negedge clk);
    bus.stream_start = 1'b0;
    while (cnt < int'(HDR_LEN) && cyc < 100) begin
      bus.stream_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      snapped = (cyc == snap_at);
      bus.snap = snapped;
      check({name, "_valid"}, 32'(bus.stream_valid), 32'd1);
      if (bus.stream_valid === 1'b1) begin
        check({name, "_data"}, bus.stream_data, e[cnt]);
        check({name, "_last"}, 32'(bus.stream_last), 32'(cnt == int'(HDR_LEN) - 1));
        if (bus.stream_ready) cnt++;
      end
      @(negedge clk);
      bus.snap = 1'b0;
      cyc++;
      if (snapped) check({name, "_snap_dropped"}, 32'(bus.snap_dropped), 32'd1);
    end
    bus.stream_ready = 1'b0;
    if (cyc >= 100) check({name, "_timeout"}, 32'(cyc), 32'(HDR_LEN));
    if (mode == 0) check({name, "_cycles"}, 32'(cyc), 32'(HDR_LEN));
    check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({name, "_valid_after"}, 32'(bus.stream_valid), 32'd0);
  endtask

  logic [31:0] exp_a [8];
  logic [31:0] exp_r [8];
  logic [31:0] exp_s [8];

  initial begin
    total = 0;
    bad   = 0;
    rst               = 1'b1;
    bus.snap          = 1'b0;
    bus.frame_count   = '0;
    bus.pps_count     = '0;
    bus.wr_en         = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    bus.rd_en         = 1'b0;
    bus.Address       = '0;
    bus.stream_start  = 1'b0;
    bus.stream_ready  = 1'b0;

    // Expected bursts; checksums are the XOR of the seven preceding words
    exp_a = '{MAGIC, 32'h10, 32'h20, 32'h2, 32'h11, 32'h22, 32'h33, 32'hA5A5_5A68};
    exp_r = '{MAGIC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, MAGIC};
    exp_s = '{MAGIC, 32'h99, 32'h55, 32'h1, 32'h0, 32'h0, 32'h0, 32'hA5A5_5A97};

    vecs.push_back(mk(OP_RD,   4'd0, '0,          '0,     MAGIC));
    vecs.push_back(mk(OP_RD,   4'd1, '0,          '0,     32'h0));
    vecs.push_back(mk(OP_RD,   4'd2, '0,          '0,     32'h0));
    vecs.push_back(mk(OP_RD,   4'd3, '0,          '0,     32'h0));
    vecs.push_back(mk(OP_SNAP, 4'd0, 32'h10,      32'h20, '0));
    vecs.push_back(mk(OP_SNAP, 4'd0, 32'h10,      32'h20, '0));
    vecs.push_back(mk(OP_RD,   4'd1, '0,          '0,     32'h10));
    vecs.push_back(mk(OP_RD,   4'd2, '0,          '0,     32'h20));
    vecs.push_back(mk(OP_RD,   4'd3, '0,          '0,     32'h2));
    vecs.push_back(mk(OP_WR,   4'd2, 32'hDEAD,    '0,     '0));
    vecs.push_back(mk(OP_RD,   4'd2, '0,          '0,     32'h20));
    vecs.push_back(mk(OP_WR,   4'd4, 32'h11,      '0,     '0));
    vecs.push_back(mk(OP_WR,   4'd5, 32'h22,      '0,     '0));
    vecs.push_back(mk(OP_WR,   4'd6, 32'h33,      '0,     '0));
    vecs.push_back(mk(OP_WR,   4'd7, 32'h44,      '0,     '0));
    vecs.push_back(mk(OP_WR,   4'd0, 32'hBEEF,    '0,     '0));
    vecs.push_back(mk(OP_RD,   4'd4, '0,          '0,     32'h11));
    vecs.push_back(mk(OP_RD,   4'd7, '0,          '0,     32'h44));
    vecs.push_back(mk(OP_RD,   4'd0, '0,          '0,     MAGIC));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data_out",     bus.data_out, 32'h0);
    check("rst_data_valid",   32'(bus.data_valid), 32'd0);
    check("rst_stream_valid", 32'(bus.stream_valid), 32'd0);
    check("rst_stream_last",  32'(bus.stream_last), 32'd0);
    check("rst_busy",         32'(bus.busy), 32'd0);
    check("rst_snap_dropped", 32'(bus.snap_dropped), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RD: begin
          bus.rd_en   = 1'b1;
          bus.Address = vecs[i].addr;
        end
        OP_WR: begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = vecs[i].addr;
          bus.wr_data = vecs[i].data;
        end
        default: begin
          bus.snap        = 1'b1;
          bus.frame_count = vecs[i].data;
          bus.pps_count   = vecs[i].pps;
        end
      endcase
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.snap  = 1'b0;
      if (vecs[i].op == OP_RD) begin
        check($sformatf("vec%0d_valid", i), 32'(bus.data_valid), 32'd1);
        check($sformatf("vec%0d_rd%0d", i, vecs[i].addr), bus.data_out, vecs[i].exp);
      end else begin
        check($sformatf("vec%0d_no_valid", i), 32'(bus.data_valid), 32'd0);
      end
    end

    do_burst("burst_full", 0, -1, exp_a);

    bus.frame_count = 32'h77;
    do_burst("burst_toggle", 1, 3, exp_a);
    rd_check("after_drop_w1", 4'd1, 32'h10);
    rd_check("after_drop_w3", 4'd3, 32'h2);

    // Reset while word 3 of a burst is on the bus
    bus.stream_ready = 1'b1;
    bus.stream_start = 1'b1;
    @(negedge clk);
    bus.stream_start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_word3", bus.stream_data, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    bus.stream_ready = 1'b0;
    check("mid_rst_busy",         32'(bus.busy), 32'd0);
    check("mid_rst_stream_valid", 32'(bus.stream_valid), 32'd0);
    check("mid_rst_stream_last",  32'(bus.stream_last), 32'd0);
    check("mid_rst_data_out",     bus.data_out, 32'h0);
    check("mid_rst_data_valid",   32'(bus.data_valid), 32'd0);
    check("mid_rst_snap_dropped", 32'(bus.snap_dropped), 32'd0);
    rst = 1'b0;
    rd_check("mid_rst_w1", 4'd1, 32'h0);
    do_burst("burst_after_rst", 0, -1, exp_r);

    // Snap and stream_start on the same idle edge
    bus.frame_count = 32'h99;
    bus.pps_count   = 32'h55;
    bus.snap        = 1'b1;
    do_burst("burst_snap_start", 0, -1, exp_s);
    check("snap_start_no_drop", 32'(bus.snap_dropped), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
